// File: rtl/n101_qspi_link_arbiter.sv
// Two-master QSPI link arbiter: muxes the flashmap (inner0) and FIFO path (inner1) onto one media link.
// Ownership changes only between transactions. Optional status counters: define N101_QSPI_ARB_STATUS_EN.
//
// state | meaning
// OWN   | inner[sel] drives the outer link; switch request evaluated every cycle
// DRAIN | outer tx_valid held low until the media block drops active, then sel flips
module n101_qspi_link_arbiter #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int PROTO_W = 2
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef N101_QSPI_ARB_STATUS_EN
  output logic               io_stat_sel,
  output logic [15:0]        io_stat_switches,
  input  logic               io_stat_clr,
`endif
  output logic               io_inner0_tx_ready,
  input  logic               io_inner0_tx_valid,
  input  logic [DATA_W-1:0]  io_inner0_tx_bits,
  output logic               io_inner0_rx_valid,
  output logic [DATA_W-1:0]  io_inner0_rx_bits,
  input  logic [CNT_W-1:0]   io_inner0_cnt,
  input  logic [PROTO_W-1:0] io_inner0_fmt_proto,
  input  logic               io_inner0_fmt_endian,
  input  logic               io_inner0_fmt_iodir,
  input  logic               io_inner0_cs_set,
  input  logic               io_inner0_cs_clear,
  input  logic               io_inner0_cs_hold,
  output logic               io_inner0_active,
  input  logic               io_inner0_lock,
  output logic               io_inner1_tx_ready,
  input  logic               io_inner1_tx_valid,
  input  logic [DATA_W-1:0]  io_inner1_tx_bits,
  output logic               io_inner1_rx_valid,
  output logic [DATA_W-1:0]  io_inner1_rx_bits,
  input  logic [CNT_W-1:0]   io_inner1_cnt,
  input  logic [PROTO_W-1:0] io_inner1_fmt_proto,
  input  logic               io_inner1_fmt_endian,
  input  logic               io_inner1_fmt_iodir,
  input  logic               io_inner1_cs_set,
  input  logic               io_inner1_cs_clear,
  input  logic               io_inner1_cs_hold,
  output logic               io_inner1_active,
  input  logic               io_inner1_lock,
  input  logic               io_outer_tx_ready,
  output logic               io_outer_tx_valid,
  output logic [DATA_W-1:0]  io_outer_tx_bits,
  input  logic               io_outer_rx_valid,
  input  logic [DATA_W-1:0]  io_outer_rx_bits,
  output logic [CNT_W-1:0]   io_outer_cnt,
  output logic [PROTO_W-1:0] io_outer_fmt_proto,
  output logic               io_outer_fmt_endian,
  output logic               io_outer_fmt_iodir,
  output logic               io_outer_cs_set,
  output logic               io_outer_cs_clear,
  output logic               io_outer_cs_hold,
  input  logic               io_outer_active
);

  typedef enum logic {OWN = 1'b0, DRAIN = 1'b1} state_t;

  state_t state;
  logic   sel;
  logic   own_tx_valid;
  logic   own_lock;
  logic   oth_tx_valid;
  logic   oth_lock;
  logic   switch_req;
  logic   tx_ready_gate;

  always_comb begin
    own_tx_valid = sel ? io_inner1_tx_valid : io_inner0_tx_valid;
    own_lock     = sel ? io_inner1_lock     : io_inner0_lock;
    oth_tx_valid = sel ? io_inner0_tx_valid : io_inner1_tx_valid;
    oth_lock     = sel ? io_inner0_lock     : io_inner1_lock;
    switch_req   = !own_lock && !own_tx_valid && (oth_tx_valid || oth_lock);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= OWN;
      sel   <= 1'b0;
    end else begin
      case (state)
        OWN: begin
          if (switch_req) state <= DRAIN;
        end
        DRAIN: begin
          // owner requests seen here are deliberately ignored; the handoff always completes
          if (!io_outer_active) begin
            sel   <= ~sel;
            state <= OWN;
          end
        end
        default: state <= OWN;
      endcase
    end
  end

  // Outer request fields keep mirroring the old owner during DRAIN so in-flight rx finishes cleanly.
  always_comb begin
    tx_ready_gate       = (state == OWN) && io_outer_tx_ready;
    io_outer_tx_valid   = (state == OWN) && own_tx_valid;
    io_outer_tx_bits    = sel ? io_inner1_tx_bits    : io_inner0_tx_bits;
    io_outer_cnt        = sel ? io_inner1_cnt        : io_inner0_cnt;
    io_outer_fmt_proto  = sel ? io_inner1_fmt_proto  : io_inner0_fmt_proto;
    io_outer_fmt_endian = sel ? io_inner1_fmt_endian : io_inner0_fmt_endian;
    io_outer_fmt_iodir  = sel ? io_inner1_fmt_iodir  : io_inner0_fmt_iodir;
    io_outer_cs_set     = sel ? io_inner1_cs_set     : io_inner0_cs_set;
    io_outer_cs_clear   = sel ? io_inner1_cs_clear   : io_inner0_cs_clear;
    io_outer_cs_hold    = sel ? io_inner1_cs_hold    : io_inner0_cs_hold;
    io_inner0_tx_ready  = !sel && tx_ready_gate;
    io_inner1_tx_ready  =  sel && tx_ready_gate;
    io_inner0_rx_valid  = !sel && io_outer_rx_valid;
    io_inner1_rx_valid  =  sel && io_outer_rx_valid;
    io_inner0_active    = !sel && io_outer_active;
    io_inner1_active    =  sel && io_outer_active;
    io_inner0_rx_bits   = io_outer_rx_bits;
    io_inner1_rx_bits   = io_outer_rx_bits;
  end

`ifdef N101_QSPI_ARB_STATUS_EN
  logic [15:0] switch_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      switch_cnt <= 16'h0000;
    end else if (io_stat_clr) begin
      switch_cnt <= 16'h0000;
    end else if ((state == DRAIN) && !io_outer_active && (switch_cnt != 16'hFFFF)) begin
      switch_cnt <= switch_cnt + 16'h0001;
    end
  end

  assign io_stat_sel      = sel;
  assign io_stat_switches = switch_cnt;
`endif

endmodule

// File: doc/n101_qspi_link_arbiter.md
Name: n101_qspi_link_arbiter

Overview:
- Shares one physical QSPI link between two link masters: inner0 is the memory-mapped flash reader (flashmap); inner1 is the software FIFO/register path.
- Sits between those masters and the QSPI media/PHY block, with one full link bundle per side.
- Hands off ownership only at transaction boundaries, using each master's lock signal, and drains the outer link before changing the select.

Parameters:
DATA_W, 8, width of tx_bits/rx_bits
CNT_W, 8, width of link cnt
PROTO_W, 2, width of fmt_proto

Ports:
clock  in  1  single clock
reset_n  in  1  asynchronous active-low reset
Inner bundle, repeated for k=0 (flashmap) and k=1 (FIFO path):
io_inner{k}_tx_ready  out  1  link accepted the tx beat
io_inner{k}_tx_valid  in  1  tx beat request
io_inner{k}_tx_bits  in  DATA_W  tx data
io_inner{k}_rx_valid  out  1  rx data valid
io_inner{k}_rx_bits  out  DATA_W  rx data
io_inner{k}_cnt  in  CNT_W  bit count
io_inner{k}_fmt_proto  in  PROTO_W  single/dual/quad
io_inner{k}_fmt_endian  in  1  bit order
io_inner{k}_fmt_iodir  in  1  1=tx, 0=rx
io_inner{k}_cs_set / _cs_clear / _cs_hold  in  1 each  chip-select controls
io_inner{k}_active  out  1  link busy for this master
io_inner{k}_lock  in  1  master requests to keep ownership
Outer bundle (to media block): same signal names with prefix io_outer_ and every direction reversed; no io_outer_lock.

Behaviour:
- Registers:
  - sel (1 bit, owner index).
  - state in {OWN=0, DRAIN=1}.
  - Reset values: sel=0, state=OWN.
  - Reset is asynchronous and may hit mid-transfer; ownership returns to inner0 immediately.
- OWN, datapath:
  - The outer bundle (tx_valid, tx_bits, cnt, fmt_*, cs_*) is a combinational mux of the inner[sel] bundle.
  - inner[sel].tx_ready = outer.tx_ready; inner[sel].active = outer.active.
  - inner[~sel]: tx_ready=0, rx_valid=0, active=0.
- rx routing:
  - rx_bits are broadcast to both inner ports.
  - rx_valid goes only to inner[sel], in both states.
- Values after reset deassertion:
  - Outer outputs mirror inner0.
  - inner1 tx_ready, rx_valid and active are 0.
- Switch condition, evaluated in OWN every cycle:
  - owner.lock==0 AND owner.tx_valid==0 AND (other.tx_valid | other.lock)==1.
  - When true, the next state is DRAIN.
- DRAIN:
  - outer.tx_valid forced 0; tx_ready to both inners is 0.
  - Remaining outer fields still mirror the old owner, so rx of in-flight data completes.
  - When outer.active==0: sel <= ~sel and state <= OWN on the same edge.
- Grant latency:
  - From the first cycle the switch condition is true to the first cycle the new owner sees tx_ready: 2 cycles minimum (outer link idle).
  - Otherwise 1 + the number of cycles outer.active stays high.
- Boundary cases:
  - Owner asserts tx_valid or lock while in DRAIN: ignored; the switch completes and the old owner waits for ownership again.
  - Both masters idle, or only the owner requesting: no switch, sel holds.
  - Owner holds lock continuously: no switch. Starvation of the other master is permitted by design; the flashmap bounds its lock to one transaction.
  - Other master deasserts its request during DRAIN: the switch still completes (no abort).
- No combinational path from any inner tx_valid to the same inner's tx_ready, except through outer.tx_ready.

Optional Feature:
- Macro: N101_QSPI_ARB_STATUS_EN.
- Defined:
  - Adds outputs io_stat_sel (1, = sel) and io_stat_switches (16).
  - io_stat_switches is a counter that increments on each DRAIN->OWN transition, saturates at 16'hFFFF, and resets to 0.
  - Adds input io_stat_clr (1), which zeroes the counter synchronously. clr takes precedence over a simultaneous increment.
- Undefined: those ports and registers are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then inner0 sends tx_bits=8'h03 with cnt=8 -> outer shows tx_bits=8'h03 and cnt=8; inner1 tx_ready=0 throughout.
- inner0 lock=0 and idle, inner1 tx_valid=1, outer.active=0 -> DRAIN for 1 cycle; inner1 tx_ready first high 2 cycles after the request; sel=1.
- Same as the previous case but outer.active=1 for 5 more cycles -> sel flips only after active falls; inner1 granted at cycle 7; outer.tx_valid=0 during DRAIN.
- inner0 lock=1 with tx_valid=0 for 100 cycles while inner1 requests -> no switch, sel=0; inner0 drops lock -> switch within 2 cycles.
- During DRAIN, old owner inner0 receives rx_valid with rx_bits=8'hA5 -> inner0 rx_valid=1; inner1 rx_valid=0.
- STATUS_EN: perform 3 handoffs -> io_stat_switches=3; assert io_stat_clr on the same cycle as a 4th handoff -> counter=0.
